// File: rtl/ct_merge.sv
// N-to-1 round-robin packet merge with a registered output stage.
// A granted input keeps the output until its end-of-packet beat has transferred.
module ct_merge #(
  parameter int NI = 2,
  parameter int WO = 1,
  parameter int WF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WO-1:0] i_data,
  input  logic [NI-1:0]    i_valid,
  input  logic [NI*WF-1:0] i_flow,
  input  logic [NI-1:0]    i_eop,
  output logic [NI-1:0]    o_ready,
  output logic [WO-1:0]    o_data,
  output logic             o_valid,
  output logic [WF-1:0]    o_flow,
  output logic             o_eop,
  input  logic             i_ready
);

  localparam int WP = (NI > 1) ? $clog2(NI) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  state_t        state_next;
  logic [WP-1:0] lock_idx;
  logic [WP-1:0] lock_next;
  logic [WP-1:0] rr_ptr;
  logic [WP-1:0] rr_next;

  logic          grant_ok;
  logic [WP-1:0] grant_idx;
  int            cand;

  logic          g_valid;
  logic          g_eop;
  logic [WO-1:0] g_data;
  logic [WF-1:0] g_flow;

  logic          load;
  logic          take;

  assign load = !o_valid || i_ready;
  assign take = load && grant_ok && g_valid;

  // Locked packets own the output; otherwise scan from rr_ptr with wrap-around.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (state == LOCKED) begin
      grant_ok  = 1'b1;
      grant_idx = lock_idx;
    end else begin
      for (int i = 0; i < NI; i++) begin
        cand = (int'(rr_ptr) + i) % NI;
        for (int k = 0; k < NI; k++) begin
          if (!grant_ok && (k == cand) && i_valid[k]) begin
            grant_ok  = 1'b1;
            grant_idx = WP'(k);
          end
        end
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_eop   = 1'b0;
    g_data  = '0;
    g_flow  = '0;
    for (int k = 0; k < NI; k++) begin
      if (WP'(k) == grant_idx) begin
        g_valid = i_valid[k];
        g_eop   = i_eop[k];
        g_data  = i_data[WO*k +: WO];
        g_flow  = i_flow[WF*k +: WF];
      end
    end
  end

  // Ready is gated by reset so upstream never sees a transfer while reset is held.
  always_comb begin
    o_ready = '0;
    for (int k = 0; k < NI; k++) begin
      o_ready[k] = reset && load && grant_ok && (WP'(k) == grant_idx);
    end
  end

  always_comb begin
    state_next = state;
    lock_next  = lock_idx;
    rr_next    = rr_ptr;
    if (take) begin
      if (g_eop) begin
        state_next = IDLE;
        rr_next    = (grant_idx == WP'(NI - 1)) ? '0 : grant_idx + WP'(1);
      end else begin
        state_next = LOCKED;
        lock_next  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_next;
      lock_idx <= lock_next;
      rr_ptr   <= rr_next;
    end
  end

  // Data fields only change on a transfer; a bubble just clears o_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_flow  <= '0;
      o_eop   <= 1'b0;
    end else if (load) begin
      o_valid <= take;
      if (take) begin
        o_data <= g_data;
        o_flow <= g_flow;
        o_eop  <= g_eop;
      end
    end
  end

endmodule

// File: tb/tb_ct_merge.sv
// Directed bench for ct_merge: a 3-input instance driven from a vector table
// plus hand sequences for reset mid-packet and a single-input instance.
module tb_ct_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [23:0] m3_data;
  logic [2:0]  m3_valid;
  logic [11:0] m3_flow;
  logic [2:0]  m3_eop;
  logic [2:0]  m3_ready;
  logic [7:0]  m3_out_data;
  logic        m3_out_valid;
  logic [3:0]  m3_out_flow;
  logic        m3_out_eop;
  logic        m3_down_ready;

  logic [7:0]  m1_data;
  logic        m1_valid;
  logic [3:0]  m1_flow;
  logic        m1_eop;
  logic        m1_ready;
  logic [7:0]  m1_out_data;
  logic        m1_out_valid;
  logic [3:0]  m1_out_flow;
  logic        m1_out_eop;
  logic        m1_down_ready;

  assign m3_flow = {4'h3, 4'h2, 4'h1};
  assign m1_flow = 4'h9;

  ct_merge #(.NI(3), .WO(8), .WF(4)) dut3 (
    .clk(clk), .reset(reset),
    .i_data(m3_data), .i_valid(m3_valid), .i_flow(m3_flow), .i_eop(m3_eop),
    .o_ready(m3_ready), .o_data(m3_out_data), .o_valid(m3_out_valid),
    .o_flow(m3_out_flow), .o_eop(m3_out_eop), .i_ready(m3_down_ready)
  );

  ct_merge #(.NI(1), .WO(8), .WF(4)) dut1 (
    .clk(clk), .reset(reset),
    .i_data(m1_data), .i_valid(m1_valid), .i_flow(m1_flow), .i_eop(m1_eop),
    .o_ready(m1_ready), .o_data(m1_out_data), .o_valid(m1_out_valid),
    .o_flow(m1_out_flow), .o_eop(m1_out_eop), .i_ready(m1_down_ready)
  );

  typedef struct {
    logic [2:0] valid;
    logic [2:0] eop;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       rdy;
    logic [2:0] exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_flow;
    logic       exp_eop;
  } vec_t;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_miss = 0;

  logic [7:0] got_data[$];
  logic       got_eop[$];

  always @(posedge clk) begin
    if (reset && m1_out_valid && m1_down_ready) begin
      got_data.push_back(m1_out_data);
      got_eop.push_back(m1_out_eop);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] e,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic rdy, input logic [2:0] er, input logic ev,
                              input logic [7:0] ed, input logic [3:0] ef, input logic ee);
    vec_t r;
    r.valid = v;  r.eop = e;  r.d0 = a;  r.d1 = b;  r.d2 = c;  r.rdy = rdy;
    r.exp_ready = er;  r.exp_valid = ev;  r.exp_data = ed;  r.exp_flow = ef;  r.exp_eop = ee;
    return r;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    m3_valid      = v.valid;
    m3_eop        = v.eop;
    m3_data       = {v.d2, v.d1, v.d0};
    m3_down_ready = v.rdy;
  endtask

  task automatic check_output(input vec_t v, input string tag);
    cmp({tag, " o_valid"}, 32'(m3_out_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      cmp({tag, " o_data"}, 32'(m3_out_data), 32'(v.exp_data));
      cmp({tag, " o_flow"}, 32'(m3_out_flow), 32'(v.exp_flow));
      cmp({tag, " o_eop"},  32'(m3_out_eop),  32'(v.exp_eop));
    end
  endtask

  task automatic step1(input logic v, input logic e, input logic [7:0] d, input logic rdy,
                       input logic er, input logic ev, input logic [7:0] ed, input logic ee,
                       input string tag);
    @(negedge clk);
    m1_valid = v;  m1_eop = e;  m1_data = d;  m1_down_ready = rdy;
    n_vec++;
    #1;
    cmp({tag, " o_ready"}, 32'(m1_ready), 32'(er));
    @(posedge clk);
    #1;
    cmp({tag, " o_valid"}, 32'(m1_out_valid), 32'(ev));
    if (ev) begin
      cmp({tag, " o_data"}, 32'(m1_out_data), 32'(ed));
      cmp({tag, " o_eop"},  32'(m1_out_eop),  32'(ee));
    end
  endtask

  initial begin
    vec_t tbl[22];
    logic [7:0] exp1_data[3];
    logic       exp1_eop[3];

    // Round-robin over continuous single-beat packets.
    tbl[0]  = mk(3'b111, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1, 3'b001, 1, 8'hA0, 4'h1, 1);
    tbl[1]  = mk(3'b111, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1, 3'b010, 1, 8'hB0, 4'h2, 1);
    tbl[2]  = mk(3'b111, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1, 3'b100, 1, 8'hC0, 4'h3, 1);
    tbl[3]  = mk(3'b111, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1, 3'b001, 1, 8'hA0, 4'h1, 1);
    tbl[4]  = mk(3'b111, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1, 3'b010, 1, 8'hB0, 4'h2, 1);
    tbl[5]  = mk(3'b111, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1, 3'b100, 1, 8'hC0, 4'h3, 1);
    tbl[6]  = mk(3'b111, 3'b111, 8'hA0, 8'hB0, 8'hC0, 1, 3'b001, 1, 8'hA0, 4'h1, 1);
    // Input 1 four-beat packet with a valid gap after beat 2.
    tbl[7]  = mk(3'b111, 3'b101, 8'hA1, 8'h11, 8'hC1, 1, 3'b010, 1, 8'h11, 4'h2, 0);
    tbl[8]  = mk(3'b111, 3'b101, 8'hA1, 8'h12, 8'hC1, 1, 3'b010, 1, 8'h12, 4'h2, 0);
    tbl[9]  = mk(3'b101, 3'b101, 8'hA1, 8'h12, 8'hC1, 1, 3'b010, 0, 8'h00, 4'h0, 0);
    tbl[10] = mk(3'b111, 3'b101, 8'hA1, 8'h13, 8'hC1, 1, 3'b010, 1, 8'h13, 4'h2, 0);
    tbl[11] = mk(3'b111, 3'b111, 8'hA1, 8'h14, 8'hC1, 1, 3'b010, 1, 8'h14, 4'h2, 1);
    tbl[12] = mk(3'b111, 3'b111, 8'hA1, 8'hB1, 8'hC1, 1, 3'b100, 1, 8'hC1, 4'h3, 1);
    // Downstream backpressure for three cycles, then resume.
    tbl[13] = mk(3'b111, 3'b111, 8'hA2, 8'hB2, 8'hC2, 0, 3'b000, 1, 8'hC1, 4'h3, 1);
    tbl[14] = mk(3'b111, 3'b111, 8'hA2, 8'hB2, 8'hC2, 0, 3'b000, 1, 8'hC1, 4'h3, 1);
    tbl[15] = mk(3'b111, 3'b111, 8'hA2, 8'hB2, 8'hC2, 0, 3'b000, 1, 8'hC1, 4'h3, 1);
    tbl[16] = mk(3'b111, 3'b111, 8'hA2, 8'hB2, 8'hC2, 1, 3'b001, 1, 8'hA2, 4'h1, 1);
    tbl[17] = mk(3'b111, 3'b111, 8'hA2, 8'hB2, 8'hC2, 1, 3'b010, 1, 8'hB2, 4'h2, 1);
    // rr_ptr=2 with only input 0 valid wraps to 0, then pointer sits at 1.
    tbl[18] = mk(3'b001, 3'b111, 8'hA3, 8'hB3, 8'hC3, 1, 3'b001, 1, 8'hA3, 4'h1, 1);
    tbl[19] = mk(3'b011, 3'b111, 8'hA4, 8'hB4, 8'hC4, 1, 3'b010, 1, 8'hB4, 4'h2, 1);
    tbl[20] = mk(3'b000, 3'b111, 8'hA4, 8'hB4, 8'hC4, 1, 3'b000, 0, 8'h00, 4'h0, 0);
    // Input 2 starts a three-beat packet; reset arrives after beat 1.
    tbl[21] = mk(3'b100, 3'b011, 8'hA5, 8'hB5, 8'h21, 1, 3'b100, 1, 8'h21, 4'h3, 0);

    reset         = 1'b0;
    m3_valid      = 3'b111;
    m3_eop        = 3'b111;
    m3_data       = 24'hC0B0A0;
    m3_down_ready = 1'b1;
    m1_valid      = 1'b0;
    m1_eop        = 1'b0;
    m1_data       = 8'h00;
    m1_down_ready = 1'b1;

    #2;
    n_vec++;
    cmp("reset o_valid", 32'(m3_out_valid), 32'd0);
    cmp("reset o_data",  32'(m3_out_data),  32'd0);
    cmp("reset o_flow",  32'(m3_out_flow),  32'd0);
    cmp("reset o_eop",   32'(m3_out_eop),   32'd0);
    cmp("reset o_ready", 32'(m3_ready),     32'd0);
    m3_valid = 3'b000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      apply_stimulus(tbl[i]);
      n_vec++;
      #1;
      cmp($sformatf("row%0d o_ready", i), 32'(m3_ready), 32'(tbl[i].exp_ready));
      @(posedge clk);
      #1;
      check_output(tbl[i], $sformatf("row%0d", i));
    end

    // Reset mid-packet: outputs drop asynchronously, arbitration restarts at 0.
    @(negedge clk);
    m3_valid = 3'b110;
    m3_eop   = 3'b111;
    m3_data  = {8'h22, 8'hB5, 8'h00};
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    cmp("async reset o_valid", 32'(m3_out_valid), 32'd0);
    cmp("async reset o_ready", 32'(m3_ready),     32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    cmp("post reset o_ready", 32'(m3_ready), 32'b010);
    @(posedge clk);
    #1;
    cmp("post reset o_valid", 32'(m3_out_valid), 32'd1);
    cmp("post reset o_data",  32'(m3_out_data),  32'hB5);
    cmp("post reset o_flow",  32'(m3_out_flow),  32'h2);
    @(negedge clk);
    #1;
    n_vec++;
    cmp("after B5 o_ready", 32'(m3_ready), 32'b100);
    @(posedge clk);
    #1;
    cmp("after B5 o_data", 32'(m3_out_data), 32'h22);
    cmp("after B5 o_eop",  32'(m3_out_eop),  32'd1);
    @(negedge clk);
    m3_valid = 3'b000;

    // Single-input instance, downstream ready toggling 1,0,1,1.
    step1(1, 0, 8'h31, 1, 1, 1, 8'h31, 0, "ni1 beat1");
    cmp("ni1 o_flow", 32'(m1_out_flow), 32'h9);
    step1(1, 0, 8'h32, 0, 0, 1, 8'h31, 0, "ni1 stall");
    step1(1, 0, 8'h32, 1, 1, 1, 8'h32, 0, "ni1 beat2");
    step1(1, 1, 8'h33, 1, 1, 1, 8'h33, 1, "ni1 beat3");
    step1(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, "ni1 idle");

    exp1_data[0] = 8'h31;  exp1_eop[0] = 1'b0;
    exp1_data[1] = 8'h32;  exp1_eop[1] = 1'b0;
    exp1_data[2] = 8'h33;  exp1_eop[2] = 1'b1;
    n_vec++;
    cmp("ni1 transfer count", 32'(got_data.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (got_data.size() > i) begin
        cmp($sformatf("ni1 xfer%0d data", i), 32'(got_data[i]), 32'(exp1_data[i]));
        cmp($sformatf("ni1 xfer%0d eop", i),  32'(got_eop[i]),  32'(exp1_eop[i]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
